l2_line_responder: RTL and testbench



---
 rtl/l2_line_responder_if.sv | 37 +++
 rtl/l2_line_responder.sv | 83 ++++++++
 tb/tb_l2_line_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/l2_line_responder_if.sv
// Bus bundle between the cache arbiter / physical memory and the L2 line responder.
// The responder uses the slave view; the surrounding environment uses the master view.
interface l2_line_responder_if #(
    parameter int WORD_W = 16,
    parameter int BEATS  = 8,
    parameter int ADDR_W = 16
) ();
    localparam int LINE_W = WORD_W * BEATS;

    logic              l2_mem_read;
    logic              l2_mem_write;
    logic [ADDR_W-1:0] l2_mem_address;
    logic [LINE_W-1:0] l2_mem_wdata;
    logic              l2_mem_resp;
    logic [LINE_W-1:0] l2_mem_rdata;

    logic              pmem_req;
    logic              pmem_we;
    logic [ADDR_W-1:0] pmem_addr;
    logic [WORD_W-1:0] pmem_wdata;
    logic [WORD_W-1:0] pmem_rdata;
    logic              pmem_ack;

    modport slave (
        input  l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata,
        output l2_mem_resp, l2_mem_rdata,
        output pmem_req, pmem_we, pmem_addr, pmem_wdata,
        input  pmem_rdata, pmem_ack
    );

    modport master (
        output l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata,
        input  l2_mem_resp, l2_mem_rdata,
        input  pmem_req, pmem_we, pmem_addr, pmem_wdata,
        output pmem_rdata, pmem_ack
    );
endinterface

// File: rtl/l2_line_responder.sv
// Services one full-line L2 read/write as a burst of word beats on physical memory,
// then pulses l2_mem_resp once with the assembled line.
module l2_line_responder #(
    parameter int WORD_W = 16,
    parameter int BEATS  = 8,
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    l2_line_responder_if.slave   bus
);
    localparam int LINE_W = WORD_W * BEATS;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int WORD_B = WORD_W / 8;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t                       state, state_nxt;
    logic [BEAT_W-1:0]            beat;
    logic [ADDR_W-1:0]            line_addr;
    logic [BEATS-1:0][WORD_W-1:0] wdata_q;
    logic [BEATS-1:0][WORD_W-1:0] rdata_q;
    logic                         busy;
    logic                         beat_done;
    logic                         last_beat;
    logic                         start;

    assign busy      = (state == RD) || (state == WR);
    assign beat_done = busy && bus.pmem_ack;
    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign start     = (state == IDLE) && (bus.l2_mem_read || bus.l2_mem_write);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.pmem_req    = busy;
        bus.pmem_we     = (state == WR);
        bus.pmem_addr   = '0;
        bus.pmem_wdata  = '0;
        bus.l2_mem_resp = (state == RESP);
        if (busy) begin
            bus.pmem_addr  = line_addr + ADDR_W'(beat) * ADDR_W'(WORD_B);
            bus.pmem_wdata = wdata_q[beat];
        end
        case (state)
            IDLE: begin
                // read has priority when both requests are raised together
                if (bus.l2_mem_read)       state_nxt = RD;
                else if (bus.l2_mem_write) state_nxt = WR;
            end
            RD, WR:  if (beat_done && last_beat) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beat      <= '0;
            line_addr <= '0;
            wdata_q   <= '0;
        end else if (start) begin
            beat      <= '0;
            line_addr <= {bus.l2_mem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            if (!bus.l2_mem_read) wdata_q <= bus.l2_mem_wdata;
        end else if (beat_done) begin
            beat <= last_beat ? '0 : beat + 1'b1;
        end
    end

    // rdata is architectural: it persists across writes and idle periods
    always_ff @(posedge clk) begin
        if (!reset_n)                          rdata_q       <= '0;
        else if (state == RD && bus.pmem_ack)  rdata_q[beat] <= bus.pmem_rdata;
    end

    assign bus.l2_mem_rdata = rdata_q;
endmodule

// File: tb/tb_l2_line_responder.sv
// Scoreboard bench for l2_line_responder: stimulus pushes expected beats/responses,
// a monitor pops and compares them whenever the DUT presents a beat or a resp.
module tb_l2_line_responder;
    localparam int WORD_W = 16;
    localparam int BEATS  = 8;
    localparam int ADDR_W = 16;
    localparam int LINE_W = WORD_W * BEATS;

    localparam logic [127:0] R1  = 128'h123E_123C_123A_1238_1236_1234_1232_1230;
    localparam logic [127:0] WD  = 128'hA007_A006_A005_A004_A003_A002_A001_A000;
    localparam logic [127:0] R2  = 128'h200E_200C_200A_2008_2006_2004_2002_2000;
    localparam logic [127:0] R3  = 128'h300E_300C_300A_3008_3006_3004_3002_3000;
    localparam logic [127:0] WD2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] R5  = 128'h500E_500C_500A_5008_5006_5004_5002_5000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    l2_line_responder_if #(.WORD_W(WORD_W), .BEATS(BEATS), .ADDR_W(ADDR_W)) bus ();

    l2_line_responder #(.WORD_W(WORD_W), .BEATS(BEATS), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } beat_t;

    beat_t        beat_q[$];
    logic [127:0] resp_q[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           mem_waits = 0;
    logic         force_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: word returned = its byte address, ack after mem_waits wait cycles
    initial begin
        int          wcnt;
        logic        prev_wait;
        logic [15:0] pa, pw;
        wcnt = 0;
        prev_wait = 1'b0;
        pa = '0;
        pw = '0;
        bus.pmem_ack = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pmem_req) begin
                if (prev_wait) begin
                    check("hold_addr", 128'(bus.pmem_addr), 128'(pa));
                    check("hold_wdata", 128'(bus.pmem_wdata), 128'(pw));
                end
                pa = bus.pmem_addr;
                pw = bus.pmem_wdata;
                if (wcnt == mem_waits) begin
                    bus.pmem_ack = 1'b1;
                    bus.pmem_rdata = bus.pmem_addr;
                    wcnt = 0;
                    prev_wait = 1'b0;
                end else begin
                    bus.pmem_ack = 1'b0;
                    wcnt++;
                    prev_wait = 1'b1;
                end
            end else begin
                bus.pmem_ack = force_ack;
                wcnt = 0;
                prev_wait = 1'b0;
            end
        end
    end

    initial begin
        beat_t        eb;
        logic [127:0] er;
        forever begin
            @(negedge clk);
            if (bus.pmem_req && bus.pmem_ack) begin
                if (beat_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got addr %h, expected no beat", bus.pmem_addr);
                end else begin
                    eb = beat_q.pop_front();
                    check("beat_addr", 128'(bus.pmem_addr), 128'(eb.addr));
                    check("beat_we", 128'(bus.pmem_we), 128'(eb.we));
                    if (eb.we) check("beat_wdata", 128'(bus.pmem_wdata), 128'(eb.wdata));
                end
            end
            if (bus.l2_mem_resp) begin
                if (resp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got resp at cycle %0d, expected none", cyc);
                end else begin
                    er = resp_q.pop_front();
                    check("resp_rdata", bus.l2_mem_rdata, er);
                end
            end
        end
    end

    task automatic push_burst(input logic [15:0] addr, input logic we, input logic [127:0] wd,
                              input int nb, input logic do_resp, input logic [127:0] exp_rdata);
        beat_t       b;
        logic [15:0] base;
        base = {addr[15:4], 4'h0};
        for (int i = 0; i < nb; i++) begin
            b.addr  = base + 16'(2 * i);
            b.we    = we;
            b.wdata = wd[i*16 +: 16];
            beat_q.push_back(b);
        end
        if (do_resp) resp_q.push_back(exp_rdata);
    endtask

    task automatic wait_resp(input string name, input int t0, input int exp_lat);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            // scramble request fields mid-burst; they must be ignored
            if (k == 2) begin
                bus.l2_mem_address = ~bus.l2_mem_address;
                bus.l2_mem_wdata   = ~bus.l2_mem_wdata;
            end
            if (bus.l2_mem_resp) break;
        end
        if (k == 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got no resp within 300 cycles, expected resp at latency %0d", name, exp_lat);
        end else begin
            check(name, 128'(cyc - t0), 128'(exp_lat));
        end
        bus.l2_mem_read  = 1'b0;
        bus.l2_mem_write = 1'b0;
    endtask

    task automatic run(input string name, input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [127:0] wd, input int waits, input logic exp_we,
                       input logic [127:0] exp_rdata, input int exp_lat);
        int t0;
        @(negedge clk);
        mem_waits = waits;
        push_burst(addr, exp_we, wd, BEATS, 1'b1, exp_rdata);
        bus.l2_mem_address = addr;
        bus.l2_mem_wdata   = wd;
        bus.l2_mem_read    = rd;
        bus.l2_mem_write   = wr;
        t0 = cyc;
        wait_resp(name, t0, exp_lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion before 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bus.l2_mem_read    = 1'b1;
        bus.l2_mem_write   = 1'b0;
        bus.l2_mem_address = 16'h1234;
        bus.l2_mem_wdata   = '0;
        repeat (2) begin
            @(negedge clk);
            check("rst_req", 128'(bus.pmem_req), 128'(0));
            check("rst_resp", 128'(bus.l2_mem_resp), 128'(0));
            check("rst_rdata", bus.l2_mem_rdata, 128'(0));
            check("rst_addr", 128'(bus.pmem_addr), 128'(0));
        end
        // release with the read still held: burst must start the next cycle
        push_burst(16'h1234, 1'b0, '0, BEATS, 1'b1, R1);
        reset_n = 1'b1;
        t0 = cyc;
        wait_resp("lat_read0", t0, 9);

        run("lat_wr_wait", 1'b0, 1'b1, 16'h0040, WD, 2, 1'b1, R1, 25);
        run("lat_rdwr", 1'b1, 1'b1, 16'h2008, ~WD, 1, 1'b0, R2, 17);
        run("lat_b2b_rd", 1'b1, 1'b0, 16'h3000, '0, 0, 1'b0, R3, 9);
        run("lat_b2b_wr", 1'b0, 1'b1, 16'h3010, WD2, 0, 1'b1, R3, 9);

        // stray ack while idle must not start anything
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_req", 128'(bus.pmem_req), 128'(0));
        check("stray_ack_resp", 128'(bus.l2_mem_resp), 128'(0));

        // reset while beat 4 of a read is on the bus
        @(negedge clk);
        mem_waits = 0;
        push_burst(16'h4000, 1'b0, '0, 5, 1'b0, '0);
        bus.l2_mem_address = 16'h4000;
        bus.l2_mem_read    = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        bus.l2_mem_read = 1'b0;
        @(negedge clk);
        check("midrst_req", 128'(bus.pmem_req), 128'(0));
        check("midrst_resp", 128'(bus.l2_mem_resp), 128'(0));
        check("midrst_rdata", bus.l2_mem_rdata, 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        run("lat_after_rst", 1'b1, 1'b0, 16'h5006, '0, 0, 1'b0, R5, 9);

        repeat (4) @(negedge clk);
        check("beats_left", 128'(beat_q.size()), 128'(0));
        check("resps_left", 128'(resp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
